// File: rtl/xnor_scoreboard_if.sv
// Handshake and result bundle between the bench controller and the XNOR scoreboard.
// The master drives run control and sample data; the slave returns run status and results.
interface xnor_scoreboard_if #(
   parameter int WIDTH  = 1,
   parameter int CNT_W  = 16,
   parameter int TIME_W = 20
);
   logic              start;
   logic              stop;
   logic              sample_valid;
   logic [WIDTH-1:0]  ref_out;
   logic [WIDTH-1:0]  dut_out;
   logic              busy;
   logic              done;
   logic              timed_out;
   logic              pass;
   logic [CNT_W-1:0]  sample_count;
   logic [CNT_W-1:0]  error_count;
   logic [TIME_W-1:0] first_error_cycle;
   logic [WIDTH-1:0]  first_error_bits;
   logic [TIME_W-1:0] cycle_count;

   modport master (
      output start, stop, sample_valid, ref_out, dut_out,
      input  busy, done, timed_out, pass, sample_count, error_count,
             first_error_cycle, first_error_bits, cycle_count
   );

   modport slave (
      input  start, stop, sample_valid, ref_out, dut_out,
      output busy, done, timed_out, pass, sample_count, error_count,
             first_error_cycle, first_error_bits, cycle_count
   );
endinterface

// File: rtl/xnor_scoreboard.sv
// Result checker for the XNOR-gate equivalence bench: scores reference vs DUT samples
// per run, counts samples/mismatches, records the first mismatch and enforces a timeout.
module xnor_scoreboard #(
   parameter int WIDTH   = 1,
   parameter int CNT_W   = 16,
   parameter int TIME_W  = 20,
   parameter int TIMEOUT = 100000
) (
   input logic              clk,
   input logic              reset,
   xnor_scoreboard_if.slave sb
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [TIME_W-1:0] LAST_CYCLE = TIME_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_sampleCount;
   logic [CNT_W-1:0]  r_errorCount;
   logic [TIME_W-1:0] r_cycleCount;
   logic [TIME_W-1:0] r_firstErrorCycle;
   logic [WIDTH-1:0]  r_firstErrorBits;
   logic              r_timedOut;
   logic [WIDTH-1:0]  w_diff;
   logic              w_mismatch;
   logic              w_timeoutHit;
   logic              w_launch;

   assign w_diff       = sb.ref_out ^ sb.dut_out;
   assign w_mismatch   = sb.sample_valid && (w_diff != '0);
   assign w_timeoutHit = (r_state == RUN) && (r_cycleCount == LAST_CYCLE);
   assign w_launch     = (r_state != RUN) && sb.start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The timeout edge ends the run even when stop arrives on the same edge.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE, DONE: if (sb.start) w_nextState = RUN;
         RUN:        if (sb.stop || w_timeoutHit) w_nextState = DONE;
         default:    w_nextState = IDLE;
      endcase
   end

   // Counters freeze outside RUN so DONE holds the last run's results until restart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sampleCount     <= '0;
         r_errorCount      <= '0;
         r_cycleCount      <= '0;
         r_firstErrorCycle <= '0;
         r_firstErrorBits  <= '0;
         r_timedOut        <= 1'b0;
      end else if (w_launch) begin
         r_sampleCount     <= '0;
         r_errorCount      <= '0;
         r_cycleCount      <= '0;
         r_firstErrorCycle <= '0;
         r_firstErrorBits  <= '0;
         r_timedOut        <= 1'b0;
      end else if (r_state == RUN) begin
         if (w_timeoutHit) begin
            r_timedOut <= 1'b1;
         end else begin
            r_cycleCount <= r_cycleCount + 1'b1;
         end
         if (sb.sample_valid && (r_sampleCount != CNT_MAX)) begin
            r_sampleCount <= r_sampleCount + 1'b1;
         end
         // A saturated error count never returns to zero, so the capture fires once per run.
         if (w_mismatch) begin
            if (r_errorCount == '0) begin
               r_firstErrorCycle <= r_cycleCount;
               r_firstErrorBits  <= w_diff;
            end
            if (r_errorCount != CNT_MAX) begin
               r_errorCount <= r_errorCount + 1'b1;
            end
         end
      end
   end

   always_comb begin
      sb.busy              = (r_state == RUN);
      sb.done              = (r_state == DONE);
      sb.timed_out         = r_timedOut;
      sb.pass              = (r_state == DONE) && !r_timedOut &&
                             (r_errorCount == '0) && (r_sampleCount != '0);
      sb.sample_count      = r_sampleCount;
      sb.error_count       = r_errorCount;
      sb.first_error_cycle = r_firstErrorCycle;
      sb.first_error_bits  = r_firstErrorBits;
      sb.cycle_count       = r_cycleCount;
   end
endmodule

// File: tb/tb_xnor_scoreboard.sv
// Self-checking bench for xnor_scoreboard: vector tables, hand-written corner sequences,
// and randomized runs scored against a per-run array model.
module tb_xnor_scoreboard;
   localparam int TO_A = 16;

   logic clk;
   logic reset;
   int   checkCount;
   int   passCount;

   xnor_scoreboard_if #(.WIDTH(1), .CNT_W(16), .TIME_W(20)) ifA ();
   xnor_scoreboard_if #(.WIDTH(2), .CNT_W(3),  .TIME_W(8))  ifB ();

   xnor_scoreboard #(.WIDTH(1), .CNT_W(16), .TIME_W(20), .TIMEOUT(TO_A)) dutA (
      .clk   (clk),
      .reset (reset),
      .sb    (ifA.slave)
   );

   xnor_scoreboard #(.WIDTH(2), .CNT_W(3), .TIME_W(8), .TIMEOUT(16)) dutB (
      .clk   (clk),
      .reset (reset),
      .sb    (ifB.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic start;
      logic stop;
      logic valid;
      logic refOut;
      logic dutOut;
      int   expSamples;
      int   expErrors;
      logic expBusy;
      logic expDone;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic st, input logic sp, input logic v,
                                  input logic r, input logic d, input int es,
                                  input int ee, input logic eb, input logic ed);
      vec_t t;
      t.start = st; t.stop = sp; t.valid = v; t.refOut = r; t.dutOut = d;
      t.expSamples = es; t.expErrors = ee; t.expBusy = eb; t.expDone = ed;
      vecs.push_back(t);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end else begin
         passCount++;
      end
   endtask

   task automatic applyStimulus(input logic st, input logic sp, input logic v,
                                input logic r, input logic d);
      ifA.start = st; ifA.stop = sp; ifA.sample_valid = v;
      ifA.ref_out = r; ifA.dut_out = d;
      @(posedge clk);
      #1;
      ifA.start = 1'b0; ifA.stop = 1'b0;
   endtask

   task automatic applyStimulusB(input logic st, input logic sp, input logic v,
                                 input logic [1:0] r, input logic [1:0] d);
      ifB.start = st; ifB.stop = sp; ifB.sample_valid = v;
      ifB.ref_out = r; ifB.dut_out = d;
      @(posedge clk);
      #1;
      ifB.start = 1'b0; ifB.stop = 1'b0;
   endtask

   task automatic checkAllZeroA(input string tag);
      checkOutput({tag, " busy"}, 32'(ifA.busy), 0);
      checkOutput({tag, " done"}, 32'(ifA.done), 0);
      checkOutput({tag, " timed_out"}, 32'(ifA.timed_out), 0);
      checkOutput({tag, " pass"}, 32'(ifA.pass), 0);
      checkOutput({tag, " samples"}, 32'(ifA.sample_count), 0);
      checkOutput({tag, " errors"}, 32'(ifA.error_count), 0);
      checkOutput({tag, " cycle"}, 32'(ifA.cycle_count), 0);
      checkOutput({tag, " fe_cycle"}, 32'(ifA.first_error_cycle), 0);
      checkOutput({tag, " fe_bits"}, 32'(ifA.first_error_bits), 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   stopEdge, nEdges, expS, expE, expFC, expFB, expCycle, idleEdges;
      bit   seen, expTO, expPass;
      logic v, r, d;

      checkCount = 0;
      passCount  = 0;
      reset = 1'b1;
      ifA.start = 0; ifA.stop = 0; ifA.sample_valid = 0; ifA.ref_out = 0; ifA.dut_out = 0;
      ifB.start = 0; ifB.stop = 0; ifB.sample_valid = 0; ifB.ref_out = 0; ifB.dut_out = 0;
      #2;
      checkAllZeroA("reset");
      checkOutput("reset B samples", 32'(ifB.sample_count), 0);
      #10;
      reset = 1'b0;

      // Clean run: matching XNOR values for every {a,b}, stop on the 10th sample.
      addVec(1, 0, 1, 0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) begin
         logic a, b;
         a = i[1]; b = i[0];
         addVec(0, (i == 9), 1, ~(a ^ b), ~(a ^ b), i + 1, 0, (i != 9), (i == 9));
      end
      // First-error run: cycle 0 unqualified, samples at cycles 1..8, mismatches at 3 and 6.
      addVec(1, 0, 0, 0, 0, 0, 0, 1, 0);
      addVec(0, 0, 0, 1, 0, 0, 0, 1, 0);
      for (int c = 1; c <= 8; c++) begin
         addVec(0, (c == 8), 1, 1, ((c == 3) || (c == 6)) ? 1'b0 : 1'b1, c,
                (c >= 6) ? 2 : ((c >= 3) ? 1 : 0), (c != 8), (c == 8));
      end
      // Gating run: invalid mismatches, a mid-run start, then two valid matches.
      addVec(1, 0, 0, 0, 0, 0, 0, 1, 0);
      addVec(0, 0, 0, 1, 0, 0, 0, 1, 0);
      addVec(1, 0, 0, 0, 1, 0, 0, 1, 0);
      addVec(0, 0, 0, 1, 0, 0, 0, 1, 0);
      addVec(0, 0, 0, 0, 1, 0, 0, 1, 0);
      addVec(0, 0, 1, 1, 1, 1, 0, 1, 0);
      addVec(1, 1, 1, 0, 0, 2, 0, 0, 1);
      addVec(0, 1, 1, 1, 0, 2, 0, 0, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].valid, vecs[i].refOut, vecs[i].dutOut);
         checkOutput($sformatf("vec%0d samples", i), 32'(ifA.sample_count), 32'(vecs[i].expSamples));
         checkOutput($sformatf("vec%0d errors", i), 32'(ifA.error_count), 32'(vecs[i].expErrors));
         checkOutput($sformatf("vec%0d busy", i), 32'(ifA.busy), 32'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d done", i), 32'(ifA.done), 32'(vecs[i].expDone));
         if (i == 10) begin
            checkOutput("clean pass", 32'(ifA.pass), 1);
            checkOutput("clean timed_out", 32'(ifA.timed_out), 0);
            checkOutput("clean cycle", 32'(ifA.cycle_count), 10);
         end
         if (i == 20) begin
            checkOutput("ferr cycle", 32'(ifA.first_error_cycle), 3);
            checkOutput("ferr bits", 32'(ifA.first_error_bits), 1);
            checkOutput("ferr pass", 32'(ifA.pass), 0);
            checkOutput("ferr run cycles", 32'(ifA.cycle_count), 9);
         end
      end
      checkOutput("gating pass", 32'(ifA.pass), 1);
      checkOutput("gating cycle", 32'(ifA.cycle_count), 6);

      // Timeout with no stop, then timeout coinciding with stop.
      for (int pass2 = 0; pass2 < 2; pass2++) begin
         applyStimulus(1, 0, 0, 0, 0);
         for (int e = 1; e <= TO_A; e++) begin
            applyStimulus(0, (pass2 == 1) && (e == TO_A), 1, 1, 1);
            if (e == TO_A - 1) begin
               checkOutput("timeout pre busy", 32'(ifA.busy), 1);
               checkOutput("timeout pre cycle", 32'(ifA.cycle_count), TO_A - 1);
            end
         end
         checkOutput($sformatf("timeout%0d done", pass2), 32'(ifA.done), 1);
         checkOutput($sformatf("timeout%0d cycle", pass2), 32'(ifA.cycle_count), TO_A - 1);
         checkOutput($sformatf("timeout%0d samples", pass2), 32'(ifA.sample_count), TO_A);
         checkOutput($sformatf("timeout%0d timed_out", pass2), 32'(ifA.timed_out), 1);
         checkOutput($sformatf("timeout%0d pass", pass2), 32'(ifA.pass), 0);
      end

      // Reset mid-run must clear everything before the next edge.
      applyStimulus(1, 0, 0, 0, 0);
      for (int e = 0; e < 5; e++) applyStimulus(0, 0, 1, 1, 0);
      checkOutput("prereset errors", 32'(ifA.error_count), 5);
      reset = 1'b1;
      #1;
      checkAllZeroA("midreset");
      #2;
      reset = 1'b0;

      // Saturation on the narrow-counter instance, then start+stop restart from DONE.
      applyStimulusB(1, 0, 0, 2'b00, 2'b00);
      applyStimulusB(0, 0, 0, 2'b01, 2'b00);
      for (int e = 1; e <= 10; e++) applyStimulusB(0, (e == 10), 1, 2'b10, 2'b00);
      checkOutput("sat done", 32'(ifB.done), 1);
      checkOutput("sat samples", 32'(ifB.sample_count), 7);
      checkOutput("sat errors", 32'(ifB.error_count), 7);
      checkOutput("sat fe_cycle", 32'(ifB.first_error_cycle), 1);
      checkOutput("sat fe_bits", 32'(ifB.first_error_bits), 2);
      checkOutput("sat cycle", 32'(ifB.cycle_count), 11);
      applyStimulusB(1, 1, 1, 2'b11, 2'b00);
      checkOutput("restart busy", 32'(ifB.busy), 1);
      checkOutput("restart samples", 32'(ifB.sample_count), 0);
      checkOutput("restart errors", 32'(ifB.error_count), 0);
      checkOutput("restart fe_bits", 32'(ifB.first_error_bits), 0);
      checkOutput("restart cycle", 32'(ifB.cycle_count), 0);
      applyStimulusB(0, 1, 0, 2'b00, 2'b00);
      checkOutput("empty run pass", 32'(ifB.pass), 0);

      // Randomized runs against a per-run array model.
      for (int run = 0; run < 40; run++) begin
         stopEdge = $urandom_range(1, 20);
         nEdges   = (stopEdge < TO_A) ? stopEdge : TO_A;
         expS = 0; expE = 0; expFC = 0; expFB = 0; seen = 0;
         applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         for (int e = 1; e <= nEdges; e++) begin
            v = ($urandom_range(0, 3) != 0);
            r = 1'($urandom);
            d = ((run % 4 != 0) && ($urandom_range(0, 7) == 0)) ? ~r : r;
            if (v) begin
               expS++;
               if (r != d) begin
                  if (!seen) begin
                     expFC = e - 1;
                     expFB = 1;
                     seen  = 1;
                  end
                  expE++;
               end
            end
            applyStimulus(($urandom_range(0, 7) == 0), (e == stopEdge), v, r, d);
         end
         expTO    = (stopEdge >= TO_A);
         expCycle = expTO ? TO_A - 1 : stopEdge;
         expPass  = !expTO && (expE == 0) && (expS != 0);
         checkOutput($sformatf("rand%0d done", run), 32'(ifA.done), 1);
         checkOutput($sformatf("rand%0d samples", run), 32'(ifA.sample_count), 32'(expS));
         checkOutput($sformatf("rand%0d errors", run), 32'(ifA.error_count), 32'(expE));
         checkOutput($sformatf("rand%0d cycle", run), 32'(ifA.cycle_count), 32'(expCycle));
         checkOutput($sformatf("rand%0d timed_out", run), 32'(ifA.timed_out), 32'(expTO));
         checkOutput($sformatf("rand%0d pass", run), 32'(ifA.pass), 32'(expPass));
         checkOutput($sformatf("rand%0d fe_cycle", run), 32'(ifA.first_error_cycle), 32'(expFC));
         checkOutput($sformatf("rand%0d fe_bits", run), 32'(ifA.first_error_bits), 32'(expFB));
         idleEdges = $urandom_range(0, 2);
         for (int k = 0; k < idleEdges; k++) begin
            applyStimulus(0, 1'($urandom), 1, 1'($urandom), 1'($urandom));
            checkOutput($sformatf("rand%0d hold done", run), 32'(ifA.done), 1);
            checkOutput($sformatf("rand%0d hold samples", run), 32'(ifA.sample_count), 32'(expS));
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/xnor_scoreboard.md
# xnor_scoreboard

Synthesizable result checker for the XNOR-gate equivalence bench: compares a reference output against a DUT output on every qualified sample, and counts samples and mismatches. Records the cycle and bit pattern of the first mismatch and enforces a run timeout. It sits at the receiving end of the stimulus path, after the reference model and the DUT, and exposes a pass/fail summary to the bench controller.

## Interface
- WIDTH, 1, bits compared per sample (1 for the XNOR gate `dout`)
- CNT_W, 16, width of sample and error counters
- TIME_W, 20, width of the run cycle counter and first-error timestamp
- TIMEOUT, 100000, run length in cycles before forced termination (must be < 2^TIME_W, ≥ 2)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a new run from IDLE or DONE
- stop  in  1  ends the current run (honoured in RUN only)
- sample_valid  in  1  qualifies ref_out/dut_out this cycle
- ref_out  in  WIDTH  reference model output
- dut_out  in  WIDTH  DUT output
- busy  out  1  high in RUN
- done  out  1  high in DONE
- timed_out  out  1  run ended by TIMEOUT, not stop
- pass  out  1  done & !timed_out & error_count==0 & sample_count!=0 (combinational from registers)
- sample_count  out  CNT_W  valid samples in current/last run
- error_count  out  CNT_W  mismatching samples
- first_error_cycle  out  TIME_W  cycle_count value at first mismatch
- first_error_bits  out  WIDTH  ref_out ^ dut_out at first mismatch
- cycle_count  out  TIME_W  cycles elapsed in run

## Operation
- FSM states: IDLE (reset state), RUN, DONE.
- IDLE/DONE + start: clear every counter, first_error_*, and timed_out; go to RUN. Inputs sampled on the start edge are not scored.
- RUN, each edge:
  - cycle_count += 1.
  - If sample_valid: sample_count += 1.
  - If sample_valid and ref_out != dut_out: error_count += 1.
  - If error_count was 0 on that mismatch, capture first_error_cycle = cycle_count (pre-increment) and first_error_bits = ref_out ^ dut_out.
- RUN + stop: the sample on that edge is still scored; go to DONE.
- RUN with cycle_count == TIMEOUT-1 at an edge: score the sample, set timed_out, go to DONE. If stop is asserted on the same edge, timed_out is still set.
- start in RUN is ignored. stop in IDLE/DONE is ignored. start+stop together in IDLE/DONE: start wins.
- sample_count and error_count saturate at 2^CNT_W-1 and never wrap. cycle_count cannot exceed TIMEOUT-1 because of the timeout.
- DONE holds all results stable until the next start or reset.
- Comparison is bitwise equality over all WIDTH bits. Any differing bit makes the sample a mismatch.

## Timing
- Reset (async assert, any state, including mid-run): state=IDLE; busy, done, timed_out, pass = 0; all counters, first_error_cycle, and first_error_bits = 0.
- start at edge k: busy=1 after edge k, cycle_count=0.
- Sample at edge k+n (n≥1): counters reflect it after that edge (1-cycle latency).
- stop at edge m: done=1 and busy=0 after edge m. Final counters are valid in the same cycle done rises.
- Timeout: done rises after the edge where cycle_count was TIMEOUT-1, i.e. TIMEOUT edges after start.
- pass is valid whenever done=1 and is 0 otherwise.

## Test plan
- Reset mid-run: start, 5 valid mismatching samples, assert reset → all outputs 0 and state IDLE immediately (before the next edge).
- Clean run: start, 10 valid samples with ref_out==dut_out cycling through all {a,b}-derived values, stop on 10th → sample_count=10, error_count=0, done=1, pass=1, timed_out=0.
- First-error capture: start, samples at cycles 1–8, mismatch (ref=1, dut=0) at cycle 3 and again at 6, stop → error_count=2, first_error_cycle=3, first_error_bits=1, pass=0.
- Gating and ignores: sample_valid=0 with mismatching data for 4 cycles, then 2 matching valid samples; start pulsed during RUN; stop → sample_count=2, error_count=0, counters not cleared by the mid-run start.
- Timeout: TIMEOUT=16, start, never stop, valid every cycle → done after 16 edges, cycle_count=15, sample_count=16, timed_out=1, pass=0. Simultaneous stop at the final edge still gives timed_out=1.
- Saturation and restart: CNT_W=3, 10 mismatching valid samples, stop → sample_count=7, error_count=7. Then start+stop in DONE → counters cleared, state RUN.
